// File: rtl/pc_branch_unit_pkg.sv
// Shared CPU definitions for the PC / conditional-branch unit: datapath widths,
// branch FSM state encoding and the branch-offset sign-extension helper.
package pc_branch_unit_pkg;

  localparam int PC_WIDTH     = 32;
  localparam int OFFSET_WIDTH = 19;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_CON = 2'd2,
    APPLY    = 2'd3
  } br_state_e;

  function automatic logic [PC_WIDTH-1:0] sext_offset(input logic [OFFSET_WIDTH-1:0] off);
    return {{(PC_WIDTH-OFFSET_WIDTH){off[OFFSET_WIDTH-1]}}, off};
  endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Branch target computation: PC plus the sign-extended IR C-field offset,
// wrapping modulo 2^32.
module branch_target_adder
  import pc_branch_unit_pkg::*;
(
  input  logic [PC_WIDTH-1:0]     pc_i,
  input  logic [OFFSET_WIDTH-1:0] offset_i,
  output logic [PC_WIDTH-1:0]     target_o
);

  assign target_o = pc_i + sext_offset(offset_i);

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with load/increment and a conditional-branch handshake with the
// CON stage. Optional taken/not-taken statistics are enabled by PC_BRANCH_STATS_EN.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] PC_RESET       = 32'h0000_0000,
  parameter int unsigned         TIMEOUT_CYCLES = 15
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic [PC_WIDTH-1:0]     bus_in,
  input  logic                    pc_load,
  input  logic                    pc_inc,
  input  logic                    br_start,
  input  logic [OFFSET_WIDTH-1:0] br_offset,
  input  logic                    con_valid,
  input  logic                    condition,
  output logic                    con_enable,
  output logic [PC_WIDTH-1:0]     pc_out,
  output logic                    busy,
  output logic                    br_done,
  output logic                    br_taken,
  output logic                    br_timeout
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [15:0]             taken_count,
  output logic [15:0]             not_taken_count
`endif
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  br_state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]       pc_q, pc_d;
  logic [OFFSET_WIDTH-1:0]   offset_q, offset_d;
  logic                      cond_q, cond_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [PC_WIDTH-1:0]       target;

  branch_target_adder u_target (
    .pc_i     (pc_q),
    .offset_i (offset_q),
    .target_o (target)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      pc_q     <= PC_RESET;
      offset_q <= '0;
      cond_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      offset_q <= offset_d;
      cond_q   <= cond_d;
      cnt_q    <= cnt_d;
    end
  end

  // A timeout resolves in the WAIT_CON cycle that reaches the limit; a con_valid in that same cycle still wins.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    offset_d   = offset_q;
    cond_d     = cond_q;
    cnt_d      = cnt_q;
    con_enable = 1'b0;
    br_done    = 1'b0;
    br_taken   = 1'b0;
    br_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (br_start) begin
          offset_d = br_offset;
          state_d  = REQ;
        end else if (pc_load) begin
          pc_d = bus_in;
        end else if (pc_inc) begin
          pc_d = pc_q + 32'd1;
        end
      end
      REQ: begin
        con_enable = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_CON;
      end
      WAIT_CON: begin
        if (con_valid) begin
          cond_d  = condition;
          state_d = APPLY;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_LIMIT) begin
            br_done    = 1'b1;
            br_timeout = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      APPLY: begin
        br_done  = 1'b1;
        br_taken = cond_q;
        if (cond_q) begin
          pc_d = target;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign pc_out = pc_q;

`ifdef PC_BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, not_taken_cnt_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else if (br_done) begin
      if (br_taken) begin
        if (taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
      end else begin
        if (not_taken_cnt_q != 16'hFFFF) not_taken_cnt_q <= not_taken_cnt_q + 16'd1;
      end
    end
  end

  assign taken_count     = taken_cnt_q;
  assign not_taken_count = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Testbench for pc_branch_unit: directed vector table, hand-written timeout and
// abort sequences, then randomized traffic checked against a cycle-age reference model.
module tb_pc_branch_unit;

  localparam logic [31:0] PC_RESET_TB = 32'h0000_0000;
  localparam int          TIMEOUT_TB  = 15;

  logic        clock;
  logic        clear;
  logic [31:0] bus_in;
  logic        pc_load, pc_inc, br_start;
  logic [18:0] br_offset;
  logic        con_valid, condition;
  logic        con_enable;
  logic [31:0] pc_out;
  logic        busy, br_done, br_taken, br_timeout;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] taken_count, not_taken_count;
`endif

  pc_branch_unit #(
    .PC_RESET       (PC_RESET_TB),
    .TIMEOUT_CYCLES (TIMEOUT_TB)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .bus_in     (bus_in),
    .pc_load    (pc_load),
    .pc_inc     (pc_inc),
    .br_start   (br_start),
    .br_offset  (br_offset),
    .con_valid  (con_valid),
    .condition  (condition),
    .con_enable (con_enable),
    .pc_out     (pc_out),
    .busy       (busy),
    .br_done    (br_done),
    .br_taken   (br_taken),
    .br_timeout (br_timeout)
`ifdef PC_BRANCH_STATS_EN
    ,
    .taken_count     (taken_count),
    .not_taken_count (not_taken_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        clr;
    logic [31:0] bus;
    logic        ld, inc, bs;
    logic [18:0] off;
    logic        cv, cond;
    logic [31:0] ePc;
    logic        eBusy, eCe, eDone, eTaken, eTo;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   nVectors = 0;
  int   nMiscompares = 0;

  // Reference model state: cycles elapsed since br_start (0 = idle) and the received condition (-1 = none yet).
  logic [31:0] mPc;
  logic [18:0] mOffset;
  int          mAge, mGot, mTakenCnt, mNotCnt;

  function automatic vec_t mk(logic clr, logic [31:0] bus, logic ld, logic inc, logic bs,
                              logic [18:0] off, logic cv, logic cond, logic [31:0] ePc,
                              logic eBusy, logic eCe, logic eDone, logic eTaken, logic eTo,
                              string name);
    vec_t v;
    v.clr = clr; v.bus = bus; v.ld = ld; v.inc = inc; v.bs = bs; v.off = off;
    v.cv = cv; v.cond = cond; v.ePc = ePc; v.eBusy = eBusy; v.eCe = eCe;
    v.eDone = eDone; v.eTaken = eTaken; v.eTo = eTo; v.name = name;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    clear = v.clr; bus_in = v.bus; pc_load = v.ld; pc_inc = v.inc; br_start = v.bs;
    br_offset = v.off; con_valid = v.cv; condition = v.cond;
  endtask

  task automatic driveIdle();
    clear = 1'b0; bus_in = '0; pc_load = 1'b0; pc_inc = 1'b0; br_start = 1'b0;
    br_offset = '0; con_valid = 1'b0; condition = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] ePc, input logic eBusy,
                             input logic eCe, input logic eDone, input logic eTaken, input logic eTo);
    nVectors++;
    if ({pc_out, busy, con_enable, br_done, br_taken, br_timeout} !== {ePc, eBusy, eCe, eDone, eTaken, eTo}) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got pc=%h busy=%b ce=%b done=%b taken=%b to=%b, expected pc=%h busy=%b ce=%b done=%b taken=%b to=%b",
               name, pc_out, busy, con_enable, br_done, br_taken, br_timeout,
               ePc, eBusy, eCe, eDone, eTaken, eTo);
    end
  endtask

  task automatic checkVal(input string name, input int got, input int exp);
    nVectors++;
    if (got != exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Predicts this cycle's outputs from the current inputs, then advances the model across the edge.
  task automatic modelCycle(output logic [31:0] ePc, output logic eBusy, output logic eCe,
                            output logic eDone, output logic eTaken, output logic eTo);
    ePc = mPc; eBusy = (mAge != 0); eCe = (mAge == 1);
    eDone = 1'b0; eTaken = 1'b0; eTo = 1'b0;
    if (clear) begin
      mPc = PC_RESET_TB; mOffset = '0; mAge = 0; mGot = -1; mTakenCnt = 0; mNotCnt = 0;
      ePc = PC_RESET_TB; eBusy = 1'b0; eCe = 1'b0;
    end else if (mAge == 0) begin
      if (br_start) begin
        mOffset = br_offset; mAge = 1;
      end else if (pc_load) mPc = bus_in;
      else if (pc_inc) mPc = mPc + 32'd1;
    end else if (mGot >= 0) begin
      eDone = 1'b1; eTaken = (mGot == 1);
      if (eTaken) begin
        mPc = mPc + 32'(int'($signed(mOffset)));
        if (mTakenCnt < 65535) mTakenCnt++;
      end else if (mNotCnt < 65535) mNotCnt++;
      mAge = 0; mGot = -1;
    end else if (mAge >= 2 && con_valid) begin
      mGot = condition ? 1 : 0; mAge++;
    end else if (mAge >= 2 && (mAge - 1) == TIMEOUT_TB) begin
      eDone = 1'b1; eTo = 1'b1; mAge = 0;
      if (mNotCnt < 65535) mNotCnt++;
    end else begin
      mAge++;
    end
  endtask

  initial begin
    logic [31:0] ePc;
    logic        eBusy, eCe, eDone, eTaken, eTo;
    logic        slowCv;
    bit          seen;
    int          doneCycle, seenTaken, seenTo, lateDone;

    driveIdle();
    clear = 1'b1;

    //            clr bus           ld inc bs off       cv cond ePc           bsy ce dn tk to
    vecs.push_back(mk(1, 32'h0,        0, 0, 0, 19'h0,     0, 0, 32'h0,        0, 0, 0, 0, 0, "reset_state"));
    vecs.push_back(mk(0, 32'h0,        0, 1, 0, 19'h0,     0, 0, 32'h0,        0, 0, 0, 0, 0, "inc_a"));
    vecs.push_back(mk(0, 32'h0,        0, 1, 0, 19'h0,     0, 0, 32'h1,        0, 0, 0, 0, 0, "inc_b"));
    vecs.push_back(mk(0, 32'h0,        0, 1, 0, 19'h0,     0, 0, 32'h2,        0, 0, 0, 0, 0, "inc_c"));
    vecs.push_back(mk(0, 32'h100,      1, 1, 0, 19'h0,     0, 0, 32'h3,        0, 0, 0, 0, 0, "inc3_result"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     0, 0, 32'h100,      0, 0, 0, 0, 0, "load_wins"));
    vecs.push_back(mk(0, 32'h0,        0, 1, 1, 19'h7FFFC, 0, 0, 32'h100,      0, 0, 0, 0, 0, "br_start_beats_inc"));
    vecs.push_back(mk(0, 32'hDEAD,     1, 1, 0, 19'h0,     0, 0, 32'h100,      1, 1, 0, 0, 0, "req_con_enable"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     1, 1, 32'h100,      1, 0, 0, 0, 0, "wait_con_valid"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     0, 0, 32'h100,      1, 0, 1, 1, 0, "apply_cycle3"));
    vecs.push_back(mk(0, 32'hFFFFFFFF, 1, 0, 0, 19'h0,     0, 0, 32'hFC,       0, 0, 0, 0, 0, "neg_offset_target"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1, 19'h2,     0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, "wrap_br_start"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     0, 0, 32'hFFFFFFFF, 1, 1, 0, 0, 0, "wrap_req"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1, 19'h5,     1, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0, "busy_ignores_start"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     0, 0, 32'hFFFFFFFF, 1, 0, 1, 1, 0, "wrap_apply"));
    vecs.push_back(mk(0, 32'hFFFFFFFF, 1, 0, 0, 19'h0,     0, 0, 32'h1,        0, 0, 0, 0, 0, "wrap_target"));
    vecs.push_back(mk(0, 32'h0,        0, 1, 0, 19'h0,     0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, "inc_at_max"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1, 19'h5,     0, 0, 32'h0,        0, 0, 0, 0, 0, "inc_wraps_zero"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     0, 0, 32'h0,        1, 1, 0, 0, 0, "nt_req"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     1, 0, 32'h0,        1, 0, 0, 0, 0, "nt_wait"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     0, 0, 32'h0,        1, 0, 1, 0, 0, "nt_apply"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1, 19'h3,     0, 0, 32'h0,        0, 0, 0, 0, 0, "nt_pc_kept"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     0, 0, 32'h0,        1, 1, 0, 0, 0, "late_req"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     0, 1, 32'h0,        1, 0, 0, 0, 0, "late_wait1"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     0, 1, 32'h0,        1, 0, 0, 0, 0, "late_wait2"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     1, 1, 32'h0,        1, 0, 0, 0, 0, "late_valid"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     0, 0, 32'h0,        1, 0, 1, 1, 0, "late_apply"));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 19'h0,     0, 0, 32'h3,        0, 0, 0, 0, 0, "late_target"));

    #1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput(vecs[i].name, vecs[i].ePc, vecs[i].eBusy, vecs[i].eCe,
                  vecs[i].eDone, vecs[i].eTaken, vecs[i].eTo);
      nextCycle();
    end

    // Timeout: con_valid never arrives; resolution lands on the 16th cycle after br_start.
    driveIdle(); pc_load = 1'b1; bus_in = 32'h55; nextCycle();
    driveIdle(); br_start = 1'b1; br_offset = 19'h7; nextCycle();
    driveIdle();
    seen = 1'b0; doneCycle = -1; seenTaken = -1; seenTo = -1;
    for (int c = 1; c <= 40 && !seen; c++) begin
      #2;
      if (br_done) begin
        seen = 1'b1; doneCycle = c; seenTaken = int'(br_taken); seenTo = int'(br_timeout);
      end
      nextCycle();
    end
    checkVal("timeout_latency", doneCycle, TIMEOUT_TB + 1);
    checkVal("timeout_flag", seenTo, 1);
    checkVal("timeout_not_taken", seenTaken, 0);
    #2;
    checkOutput("timeout_pc_kept", 32'h55, 0, 0, 0, 0, 0);
    nextCycle();

    // Abort: clear asserted while waiting in WAIT_CON.
    driveIdle(); pc_load = 1'b1; bus_in = 32'h200; nextCycle();
    driveIdle(); br_start = 1'b1; br_offset = 19'h10; nextCycle();
    driveIdle(); nextCycle();
    #2;
    checkOutput("abort_in_wait_con", 32'h200, 1, 0, 0, 0, 0);
    clear = 1'b1;
    #1;
    checkOutput("abort_clear", PC_RESET_TB, 0, 0, 0, 0, 0);
`ifdef PC_BRANCH_STATS_EN
    checkVal("abort_taken_count", int'(taken_count), 0);
    checkVal("abort_not_taken_count", int'(not_taken_count), 0);
`endif
    nextCycle();
    driveIdle(); con_valid = 1'b1; condition = 1'b1;
    lateDone = 0;
    for (int c = 0; c < 6; c++) begin
      #2;
      if (br_done || busy) lateDone++;
      nextCycle();
    end
    checkVal("abort_no_br_done", lateDone, 0);
    #2;
    checkOutput("abort_pc_reset", PC_RESET_TB, 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model, starting from a clear.
    nextCycle();
    driveIdle(); clear = 1'b1;
    mPc = PC_RESET_TB; mOffset = '0; mAge = 0; mGot = -1; mTakenCnt = 0; mNotCnt = 0;
    slowCv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) slowCv = ($urandom_range(0, 2) == 0);
      if (i > 0) clear = ($urandom_range(0, 199) == 0);
      bus_in    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom);
      pc_load   = ($urandom_range(0, 7) == 0);
      pc_inc    = ($urandom_range(0, 2) == 0);
      br_start  = ($urandom_range(0, 3) == 0);
      br_offset = 19'($urandom);
      con_valid = slowCv ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      condition = 1'($urandom_range(0, 1));
      #2;
      modelCycle(ePc, eBusy, eCe, eDone, eTaken, eTo);
      checkOutput("random", ePc, eBusy, eCe, eDone, eTaken, eTo);
      nextCycle();
`ifdef PC_BRANCH_STATS_EN
      clear = 1'b0;
      #1;
      checkVal("random_taken_count", int'(taken_count), mTakenCnt);
      checkVal("random_not_taken_count", int'(not_taken_count), mNotCnt);
      #(-0);
`endif
    end
    driveIdle();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, range 1..255, maximum WAIT_CON dwell in cycles.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 clear  in  1  reset, asynchronous, active-high.
REQ-005 bus_in  in  32  value for an absolute PC load.
REQ-006 pc_load  in  1  PC <= bus_in.
REQ-007 pc_inc  in  1  PC <= PC + 1.
REQ-008 br_start  in  1  one-cycle request to start conditional-branch evaluation.
REQ-009 br_offset  in  19  signed word offset (IR C field), sampled with br_start.
REQ-010 con_valid  in  1  condition result from the CON flip-flop stage is valid.
REQ-011 condition  in  1  branch condition from the CON stage.
REQ-012 con_enable  out  1  one-cycle strobe to the CON stage to latch its result.
REQ-013 pc_out  out  32  current PC.
REQ-014 busy  out  1  high in every state other than IDLE.
REQ-015 br_done  out  1  one-cycle pulse when a branch resolves.
REQ-016 br_taken  out  1  valid with br_done; 1 = offset applied.
REQ-017 br_timeout  out  1  valid with br_done; 1 = con_valid never arrived.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT_CON and APPLY.
REQ-019 IDLE: pc_load wins over pc_inc when both are high; either takes effect on the next edge.
REQ-020 IDLE with br_start: latch br_offset, go to REQ; br_start SHALL win over pc_load and pc_inc, which are ignored that cycle.
REQ-021 REQ: assert con_enable for exactly one cycle, clear the timeout counter, go to WAIT_CON.
REQ-022 WAIT_CON: on con_valid, latch condition and go to APPLY.
REQ-023 WAIT_CON: without con_valid, increment the counter; on reaching TIMEOUT_CYCLES, resolve as not taken with br_timeout=1 and return to IDLE.
REQ-024 APPLY: if the latched condition is 1, PC <= PC + sign_extend(offset) modulo 2^32, else PC is unchanged; assert br_done; return to IDLE.
REQ-025 Resolution latency SHALL be 3 cycles from br_start when con_valid is high in the first WAIT_CON cycle.
REQ-026 While busy, br_start, pc_load and pc_inc SHALL be ignored, with no queuing.
REQ-027 PC+1 and PC+offset SHALL wrap silently; 32'hFFFF_FFFF + 1 = 0.
REQ-028 br_done, br_taken and br_timeout SHALL be low except in the resolution cycle.

Reset
REQ-029 On clear: state=IDLE, pc_out=PC_RESET, con_enable=0, br_done=0, br_taken=0, br_timeout=0, busy=0, counter=0, latched offset=0.
REQ-030 clear mid-branch SHALL abort immediately; no br_done is produced for the aborted branch.

Configuration
REQ-031 Macro PC_BRANCH_STATS_EN.
- When defined, SHALL add outputs taken_count[15:0] and not_taken_count[15:0].
- Each counter increments on the matching br_done; a timeout counts as not taken.
- Counters saturate at 16'hFFFF and are cleared by clear.
REQ-032 When PC_BRANCH_STATS_EN is undefined, the ports and counters SHALL be absent, and all other behaviour is identical.

Structure
REQ-033 The shared CPU package SHALL hold the FSM state enum (2-bit), PC_WIDTH=32 and OFFSET_WIDTH=19.
REQ-034 The sign extension and target adder SHALL be the sub-module branch_target_adder (combinational: pc, offset -> target).

Verification
REQ-035 clear, then pc_inc 3 cycles -> pc_out=3, busy=0.
REQ-036 pc_load with bus_in=32'h0000_0100 and pc_inc in the same cycle -> pc_out=32'h100.
REQ-037 PC=32'h100, br_start, offset=19'h7FFFC (-4), con_valid=1 with condition=1 on first WAIT_CON -> br_done and br_taken at cycle 3, pc_out=32'hFC.
REQ-038 PC=32'hFFFF_FFFF, br_start, offset=2, condition=1 -> pc_out=1.
REQ-039 br_start with con_valid held low -> br_done, br_timeout=1, br_taken=0 after REQ + 15 WAIT_CON cycles; PC unchanged.
REQ-040 clear asserted in WAIT_CON -> pc_out=PC_RESET, busy=0, no br_done; with PC_BRANCH_STATS_EN, counters=0.
